// File: rtl/hacd_pkg.sv
// hacd_pkg: shared hawk AXI read packet types plus read-arbiter configuration and debug types.
package hacd_pkg;

    localparam int HAWK_RDARB_MAX_OUTST = 4;
    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 64;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            arlen;
        logic                  arvalid;
        logic                  rready;
    } axi_rd_reqpkt_t;

    typedef struct packed {
        logic arready;
    } axi_rd_rdypkt_t;

    typedef struct packed {
        logic [1:0]            rresp;
        logic [AXI_DATA_W-1:0] rdata;
        logic                  rvalid;
        logic                  rlast;
    } axi_rd_resppkt_t;

    typedef enum logic {ARB, ISSUE} rdarb_state_e;

    typedef struct packed {
        rdarb_state_e state;
        logic [2:0]   rr_ptr;
        logic [7:0]   outst_cnt;
        logic         err;
    } rdarb_dbg_t;

    function automatic int rr_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/hawk_rdarb_gntfifo.sv
// hawk_rdarb_gntfifo: synchronous FIFO of requester indices recording AR grant order.
module hawk_rdarb_gntfifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr, r_rd;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (push_i) r_wr <= r_wr + PTR_W'(1);
            if (pop_i) r_rd <= r_rd + PTR_W'(1);
            r_cnt <= r_cnt + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr] <= din_i;
    end

    assign dout_o  = r_mem[r_rd];
    assign full_o  = r_cnt == CNT_W'(DEPTH);
    assign empty_o = r_cnt == '0;
    assign cnt_o   = r_cnt;

endmodule

// File: rtl/hawk_axird_arb.sv
// hawk_axird_arb: round-robin AR arbiter sharing one AXI read master; R beats return in grant order.
// Define HAWK_RDARB_PRIO_EN for requester-0 fixed priority with per-requester starvation override.
module hawk_axird_arb
    import hacd_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MAX_OUTST = HAWK_RDARB_MAX_OUTST,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  axi_rd_reqpkt_t  [NUM_REQ-1:0]     req_i,
    output axi_rd_rdypkt_t  [NUM_REQ-1:0]     rdy_o,
    output axi_rd_resppkt_t [NUM_REQ-1:0]     resp_o,
    output axi_rd_reqpkt_t                    mst_req_o,
    input  axi_rd_rdypkt_t                    mst_rdy_i,
    input  axi_rd_resppkt_t                   mst_resp_i,
    output logic [$clog2(MAX_OUTST):0]        outst_cnt_o,
    output logic                              err_o,
    output rdarb_dbg_t                        dbg_o
);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    rdarb_state_e          r_state, w_next;
    logic [IDX_W-1:0]      r_rr_ptr, r_gnt, w_pick, w_rr_pick, w_head;
    logic [AXI_ADDR_W-1:0] r_addr;
    logic [7:0]            r_arlen;
    logic                  r_err;
    logic [NUM_REQ-1:0]    w_av;
    logic                  w_grant, w_hs, w_pop, w_full, w_empty;
    logic [CNT_W-1:0]      w_cnt, w_sum;

    always_comb begin
        w_av = '0;
        for (int k = 0; k < NUM_REQ; k++) w_av[k] = req_i[k].arvalid;
    end

    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        w_rr_pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (w_av[rr_idx(int'(r_rr_ptr), i, NUM_REQ)])
                w_rr_pick = IDX_W'(rr_idx(int'(r_rr_ptr), i, NUM_REQ));
    end

`ifdef HAWK_RDARB_PRIO_EN
    logic [7:0] r_starve [NUM_REQ-1:1];

    always_comb begin
        w_pick = w_av[0] ? '0 : w_rr_pick;
        for (int k = NUM_REQ - 1; k >= 1; k--)
            if (w_av[k] && r_starve[k] == 8'hff) w_pick = IDX_W'(k);
    end

    always_ff @(posedge clk_i) begin
        for (int k = 1; k < NUM_REQ; k++) begin
            if (rst_i) r_starve[k] <= '0;
            else if (w_grant)
                r_starve[k] <= (w_pick == IDX_W'(k)) ? 8'd0 :
                               (w_av[k] && r_starve[k] != 8'hff) ? r_starve[k] + 8'd1 : r_starve[k];
        end
    end
`else
    assign w_pick = w_rr_pick;
`endif

    // A grant is only taken with a free FIFO slot, so the later push can never overflow.
    assign w_grant = r_state == ARB && !w_full && |w_av;
    assign w_hs    = r_state == ISSUE && mst_rdy_i.arready;

    always_comb w_next = w_grant ? ISSUE : (w_hs ? ARB : r_state);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ARB;
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_addr   <= '0;
            r_arlen  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_gnt   <= w_pick;
                r_addr  <= req_i[w_pick].addr;
                r_arlen <= req_i[w_pick].arlen;
            end
            if (w_hs) r_rr_ptr <= IDX_W'(rr_idx(int'(r_gnt), 1, NUM_REQ));
            if (mst_resp_i.rvalid && w_empty) r_err <= 1'b1;
        end
    end

    hawk_rdarb_gntfifo #(.W(IDX_W), .DEPTH(MAX_OUTST)) u_gntfifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_hs),
        .pop_i   (w_pop),
        .din_i   (r_gnt),
        .dout_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .cnt_o   (w_cnt)
    );

    // With nothing outstanding rready stays high so stray beats drain instead of stalling the master.
    always_comb begin
        mst_req_o         = '0;
        mst_req_o.addr    = r_addr;
        mst_req_o.arlen   = r_arlen;
        mst_req_o.arvalid = r_state == ISSUE;
        mst_req_o.rready  = !rst_i && (w_empty || req_i[w_head].rready);
    end

    assign w_pop = !w_empty && mst_resp_i.rvalid && mst_req_o.rready && mst_resp_i.rlast;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            rdy_o[k].arready = w_hs && r_gnt == IDX_W'(k);
            resp_o[k]        = mst_resp_i;
            resp_o[k].rvalid = mst_resp_i.rvalid && !w_empty && w_head == IDX_W'(k);
            resp_o[k].rlast  = mst_resp_i.rlast && !w_empty && w_head == IDX_W'(k);
        end
    end

    assign w_sum       = w_cnt + CNT_W'(r_state == ISSUE);
    assign outst_cnt_o = (w_sum > CNT_W'(MAX_OUTST)) ? CNT_W'(MAX_OUTST) : w_sum;
    assign err_o       = r_err;
    assign dbg_o       = '{state: r_state, rr_ptr: 3'(r_rr_ptr), outst_cnt: 8'(outst_cnt_o), err: r_err};

endmodule

// File: tb/tb_hawk_axird_arb.sv
// tb_hawk_axird_arb: table-driven grant-order checks plus scoreboard-checked R routing and corner sequences.
module tb_hawk_axird_arb;
    import hacd_pkg::*;

    localparam int NR = 3;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_rd_reqpkt_t  [NR-1:0] req;
    axi_rd_rdypkt_t  [NR-1:0] rdy;
    axi_rd_resppkt_t [NR-1:0] resp;
    axi_rd_reqpkt_t           mreq;
    axi_rd_rdypkt_t           mrdy;
    axi_rd_resppkt_t          mresp;
    logic [2:0]               outst;
    logic                     err;
    rdarb_dbg_t               dbg;

    hawk_axird_arb #(.NUM_REQ(NR), .MAX_OUTST(MO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .rdy_o       (rdy),
        .resp_o      (resp),
        .mst_req_o   (mreq),
        .mst_rdy_i   (mrdy),
        .mst_resp_i  (mresp),
        .outst_cnt_o (outst),
        .err_o       (err),
        .dbg_o       (dbg)
    );

    typedef struct {
        int idx;
        int beats;
    } sb_t;

    typedef struct {
        logic [NR-1:0] mask;
        int            gnt;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   m_seq = 0;
    sb_t  sb[$];
    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] addr_of(input int k);
        return 64'h1000_0000 + (64'(k) << 12);
    endfunction

    function automatic logic [NR-1:0] rdy_vec();
        logic [NR-1:0] v;
        for (int k = 0; k < NR; k++) v[k] = rdy[k].arready;
        return v;
    endfunction

    function automatic logic [NR-1:0] rvalid_vec();
        logic [NR-1:0] v;
        for (int k = 0; k < NR; k++) v[k] = resp[k].rvalid;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ar(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!mreq.arvalid && n < 8);
        chk("ar_seen", mreq.arvalid, 1);
    endtask

    task automatic issue_check(input int exp);
        chk("ar_addr", mreq.addr, addr_of(exp));
        chk("ar_len", mreq.arlen, exp);
        chk("arready_onehot", rdy_vec(), 64'(1) << exp);
        sb.push_back('{exp, exp + 1});
    endtask

    task automatic drain_one();
        sb_t  it;
        logic quiet;
        it = sb.pop_front();
        chk("outst_pre_burst", outst, sb.size() + 1);
        for (int b = 0; b < it.beats; b++) begin
            mresp.rvalid = 1'b1;
            mresp.rlast  = (b == it.beats - 1);
            mresp.rresp  = 2'b00;
            mresp.rdata  = {32'(it.idx), 16'(m_seq), 16'(b)};
            #1;
            chk("route_rvalid", resp[it.idx].rvalid, 1);
            chk("route_rdata", resp[it.idx].rdata, mresp.rdata);
            chk("route_rlast", resp[it.idx].rlast, b == it.beats - 1);
            quiet = 1'b1;
            for (int k = 0; k < NR; k++)
                if (k != it.idx && (resp[k].rvalid || resp[k].rlast)) quiet = 1'b0;
            chk("others_quiet", quiet, 1);
            chk("mst_rready", mreq.rready, 1);
            step();
        end
        mresp.rvalid = 1'b0;
        mresp.rlast  = 1'b0;
        m_seq++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   m_ptr;
        int   nhs;
        sb_t  it;
        vecs[0]  = '{3'b111, 0};
        vecs[1]  = '{3'b111, 1};
        vecs[2]  = '{3'b111, 2};
        vecs[3]  = '{3'b111, 0};
        vecs[4]  = '{3'b111, 1};
        vecs[5]  = '{3'b111, 2};
        vecs[6]  = '{3'b110, 1};
        vecs[7]  = '{3'b001, 0};
        vecs[8]  = '{3'b101, 2};
        vecs[9]  = '{3'b011, 0};
        vecs[10] = '{3'b011, 1};
        vecs[11] = '{3'b011, 0};

        rst   = 1'b1;
        req   = '0;
        mrdy  = '0;
        mresp = '0;
        for (int k = 0; k < NR; k++) req[k].rready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outst", outst, 0);
        chk("rst_err", err, 0);
        chk("rst_arvalid", mreq.arvalid, 0);
        chk("rst_rready", mreq.rready, 0);
        chk("rst_arready", rdy_vec(), 0);
        chk("rst_rvalid", rvalid_vec(), 0);
        rst = 1'b0;
        #1;
        chk("idle_rready", mreq.rready, 1);
        @(negedge clk);

        // Grant order table with arready held high
        mrdy.arready = 1'b1;
        for (int e = 0; e < 12; e++) begin
            for (int k = 0; k < NR; k++) begin
                req[k].arvalid = vecs[e].mask[k];
                req[k].addr    = addr_of(k);
                req[k].arlen   = 8'(k);
            end
            wait_ar(n);
            chk("ar_latency", n, 1);
            issue_check(vecs[e].gnt);
            step();
            if (sb.size() == 3) begin
                for (int k = 0; k < NR; k++) req[k].arvalid = 1'b0;
                while (sb.size() > 0) drain_one();
            end
        end

        // Single requester 1, arready delayed two cycles, 4-beat burst
        mrdy.arready   = 1'b0;
        req[1].arvalid = 1'b1;
        req[1].addr    = 64'h1000;
        req[1].arlen   = 8'd3;
        wait_ar(n);
        chk("c_latency", n, 1);
        chk("c_addr", mreq.addr, 64'h1000);
        chk("c_arlen", mreq.arlen, 3);
        chk("c_no_arready", rdy_vec(), 0);
        chk("c_outst_issue", outst, 1);
        step();
        chk("c_hold_arvalid", mreq.arvalid, 1);
        step();
        mrdy.arready = 1'b1;
        #1;
        chk("c_arready_pulse", rdy_vec(), 3'b010);
        step();
        req[1].arvalid = 1'b0;
        mrdy.arready   = 1'b0;
        #1;
        chk("c_arready_gone", rdy_vec(), 0);
        chk("c_arvalid_drop", mreq.arvalid, 0);
        chk("c_outst_one", outst, 1);
        sb.push_back('{1, 4});
        drain_one();
        chk("c_outst_zero", outst, 0);
        chk("c_err", err, 0);

        // Requester 2 stalls rready mid-burst
        mrdy.arready   = 1'b1;
        req[2].arvalid = 1'b1;
        req[2].addr    = addr_of(2);
        req[2].arlen   = 8'd2;
        wait_ar(n);
        issue_check(2);
        step();
        req[2].arvalid = 1'b0;
        it = sb.pop_front();
        mresp.rvalid = 1'b1;
        mresp.rlast  = 1'b0;
        mresp.rdata  = 64'hd0;
        #1;
        chk("d_beat0", resp[it.idx].rvalid, 1);
        step();
        mresp.rdata   = 64'hd1;
        req[2].rready = 1'b0;
        #1;
        repeat (3) begin
            chk("d_stall_rready", mreq.rready, 0);
            chk("d_stall_route", rvalid_vec(), 3'b100);
            chk("d_stall_outst", outst, 1);
            step();
        end
        req[2].rready = 1'b1;
        #1;
        chk("d_resume_rready", mreq.rready, 1);
        step();
        mresp.rlast = 1'b1;
        mresp.rdata = 64'hd2;
        #1;
        chk("d_last_route", resp[2].rlast, 1);
        step();
        mresp.rvalid = 1'b0;
        mresp.rlast  = 1'b0;
        #1;
        chk("d_outst_zero", outst, 0);

        // FIFO full: all requesters held, no R responses
        m_ptr = 0;
        nhs   = 0;
        mrdy.arready = 1'b1;
        for (int k = 0; k < NR; k++) begin
            req[k].arvalid = 1'b1;
            req[k].addr    = addr_of(k);
            req[k].arlen   = 8'(k);
        end
        repeat (20) begin
            step();
            if (mreq.arvalid) begin
                issue_check(m_ptr);
                m_ptr = (m_ptr + 1) % NR;
                nhs++;
            end
        end
        chk("b_handshakes", nhs, MO);
        chk("b_outst_full", outst, MO);
        chk("b_no_fifth", mreq.arvalid, 0);
        drain_one();
        wait_ar(n);
        chk("b_fifth_within_2", n <= 2, 1);
        issue_check(m_ptr);
        step();
        for (int k = 0; k < NR; k++) req[k].arvalid = 1'b0;
        while (sb.size() > 0) drain_one();
        chk("b_outst_zero", outst, 0);

        // Stray beat with nothing outstanding
        chk("e_err_before", err, 0);
        mresp.rvalid = 1'b1;
        mresp.rlast  = 1'b1;
        #1;
        chk("e_drain_rready", mreq.rready, 1);
        chk("e_no_route", rvalid_vec(), 0);
        step();
        mresp.rvalid = 1'b0;
        mresp.rlast  = 1'b0;
        chk("e_err_set", err, 1);
        repeat (3) step();
        chk("e_err_sticky", err, 1);
        rst = 1'b1;
        step();
        chk("e_err_cleared", err, 0);
        chk("e_rst_rready", mreq.rready, 0);
        rst = 1'b0;
        step();
        chk("e_outst_after_rst", outst, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hawk_axird_arb.md
Name: hawk_axird_arb

Overview:
- Shares the single hawk AXI read master between NUM_REQ page-read requesters, e.g. ATT lookup, list/ToL manager and compression manager.
- Arbitrates AR requests round-robin and tracks granted bursts in a grant-order FIFO.
- Read responses carry no ID, so R beats route back in issue order.
- Sits between the requesters and hawk_axird_master.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MAX_OUTST, 4, maximum in-flight bursts; depth of the grant FIFO (power of 2).
- IDX_W, $clog2(NUM_REQ), width of a requester index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  NUM_REQ x axi_rd_reqpkt_t  per-requester addr/arlen/arvalid/rready.
- rdy_o  out  NUM_REQ x axi_rd_rdypkt_t  per-requester arready.
- resp_o  out  NUM_REQ x axi_rd_resppkt_t  per-requester rresp/rdata/rvalid/rlast.
- mst_req_o  out  axi_rd_reqpkt_t  to the AXI read master.
- mst_rdy_i  in  axi_rd_rdypkt_t  arready from the master.
- mst_resp_i  in  axi_rd_resppkt_t  R channel from the master.
- outst_cnt_o  out  $clog2(MAX_OUTST)+1  in-flight burst count.
- err_o  out  1  sticky: an R beat arrived with no outstanding burst.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset: state ARB, RR pointer 0, FIFO empty, outst_cnt_o=0, err_o=0; mst_req_o arvalid=0 and rready=0; all rdy_o and resp_o valids 0.
- AR state machine:
  - ARB: if FIFO not full and any req_i[k].arvalid, pick the first set k starting at the RR pointer. Register gnt=k, latch addr/arlen into mst_req_o, assert mst arvalid next cycle, go to ISSUE. If the FIFO is full, no grant.
  - ISSUE: hold mst_req_o stable with arvalid=1 until mst_rdy_i.arready.
  - On the handshake cycle: rdy_o[gnt].arready=1 for exactly that cycle; push gnt into the FIFO; RR pointer=(gnt+1) mod NUM_REQ; deassert arvalid next cycle; return to ARB.
  - Latency: requester arvalid to mst arvalid is 1 cycle. Minimum back-to-back issue is one AR per 2 cycles.
  - A requester must hold arvalid/addr/arlen until its arready. The arbiter never drops a granted request.
- R routing (combinational from the FIFO head h):
  - resp_o[h] = mst_resp_i; resp_o[other].rvalid=0 and rlast=0; data is don't-care.
  - mst_req_o.rready = req_i[h].rready when the FIFO is non-empty, else 1 (drains stray beats).
  - Pop on mst rvalid & rready & rlast. Non-last beats do not pop.
  - A beat with rvalid=1 while the FIFO is empty sets err_o, sticky until reset; the beat is dropped.
- FIFO and counter:
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo MAX_OUTST.
  - Full is count==MAX_OUTST. It blocks only new grants; a grant already in ISSUE always has a free slot, reserved at grant time.
  - outst_cnt_o = FIFO count + (state==ISSUE ? 1 : 0), capped at MAX_OUTST.
- Boundaries:
  - A requester may have several bursts outstanding; order is preserved.
  - A requester dropping arvalid in ARB before a grant is simply not selected.
  - Reset mid-burst clears everything. In-flight beats after reset set err_o; the system must quiesce the master before reset.

Optional Feature:
- HAWK_RDARB_PRIO_EN defined: requester 0 (ATT lookup, CPU-latency critical) has fixed priority over round-robin. A starvation counter (8-bit) per lower requester forces that requester's grant when it reaches 255; the counter resets on its grant.
- Undefined: pure round-robin, no counters.

Decomposition:
- hacd_pkg gains:
  - parameter HAWK_RDARB_MAX_OUTST;
  - typedef rdarb_dbg_t {state, rr_ptr, outst_cnt, err} for the debug probes.
- The existing axi_rd_reqpkt_t, axi_rd_rdypkt_t and axi_rd_resppkt_t are reused unchanged.
- Sub-module: hawk_rdarb_gntfifo, a sync FIFO of IDX_W-bit indices with push/pop/full/empty/count.

Test Plan:
- Single requester 1 issues addr=0x1000, arlen=3; master gives arready after 2 cycles, then 4 beats with rlast on the 4th -> 1-cycle rdy_o[1].arready pulse; resp_o[1] sees 4 valid beats; outst_cnt_o goes 1->0; err_o=0.
- All 3 requesters hold arvalid continuously, arready always 1 -> grant order 0,1,2,0,1,2; R beats route in the same order.
- MAX_OUTST=4, no R responses, 6 requests -> exactly 4 AR handshakes, outst_cnt_o=4, no 5th arvalid. Complete one burst -> 5th issues within 2 cycles.
- Requester 2 deasserts rready for 3 cycles mid-burst -> mst rready=0 for those cycles; beat held; no routing change.
- Stray rvalid with empty FIFO -> err_o=1 and stays 1 until rst_i.
- With HAWK_RDARB_PRIO_EN, requester 0 asserts continuously and requester 1 waits -> requester 1 granted on starvation count 255; without the macro, grants alternate 0,1.
